// File: rtl/umi_out_arbiter_if.sv
// Handshake bundle between the requesters, the shared UMI link and the arbiter.
interface umi_out_arbiter_if #(
  parameter int unsigned N = 2
);
  logic [N*256-1:0] req_packet;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [255:0]     umi_out_packet;
  logic             umi_out_valid;
  logic             umi_out_ready;
  logic [255:0]     umi_in_packet;
  logic             umi_in_valid;
  logic             umi_in_ready;
  logic [255:0]     rsp_packet;
  logic [N-1:0]     rsp_valid;
  logic [N-1:0]     rsp_ready;

  modport slave (
    input  req_packet, req_valid, umi_out_ready, umi_in_packet, umi_in_valid, rsp_ready,
    output req_ready, umi_out_packet, umi_out_valid, umi_in_ready, rsp_packet, rsp_valid
  );

  modport master (
    output req_packet, req_valid, umi_out_ready, umi_in_packet, umi_in_valid, rsp_ready,
    input  req_ready, umi_out_packet, umi_out_valid, umi_in_ready, rsp_packet, rsp_valid
  );
endinterface

// File: rtl/umi_out_arbiter.sv
// Round-robin arbiter onto one UMI outbound port; read responses are routed
// back to their issuer through an in-order requester-ID FIFO.
module umi_out_arbiter #(
  parameter int unsigned N        = 2,
  parameter int unsigned DEPTH    = 4,
  parameter logic [7:0]  UMI_READ = 8'h08
) (
  input  logic                     clk,
  input  logic                     nreset,
  umi_out_arbiter_if.slave         bus,
  output logic                     err_unexpected,
  output logic [$clog2(DEPTH):0]   outstanding
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   grant;
  logic            found;
  int unsigned     idx;
  logic [N-1:0]    is_read;
  logic [N-1:0]    eligible;
  logic [N-1:0]    req_ready_c;
  logic            accept;
  logic            push;
  logic            pop;
  logic            drop;
  logic [255:0]    out_packet;
  logic            out_valid;
  logic            err;

  logic [IW-1:0]   id_fifo [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            fifo_full, fifo_empty;
  logic [IW-1:0]   head;
  logic [N-1:0]    rsp_valid_c;
  logic            umi_in_ready_c;

  assign fifo_full  = (count == CNT_FULL);
  assign fifo_empty = (count == '0);
  assign head       = id_fifo[rd_ptr];

  // A read may only be granted while there is room to remember its issuer.
  always_comb begin
    is_read  = '0;
    eligible = '0;
    for (int unsigned i = 0; i < N; i++) begin
      is_read[i]  = (bus.req_packet[i*256 +: 8] == UMI_READ);
      eligible[i] = bus.req_valid[i] && !(is_read[i] && fifo_full);
    end
  end

  // Search starts just after the previous winner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    grant = last_grant;
    idx   = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(last_grant) + k) % N;
      if (!found && eligible[IW'(idx)]) begin
        found = 1'b1;
        grant = IW'(idx);
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    req_ready_c = '0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          req_ready_c[grant] = 1'b1;
          accept             = 1'b1;
          state_nxt          = SEND;
        end
      end
      SEND: begin
        if (bus.umi_out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign push = accept && is_read[grant];

  // Responses with nothing outstanding are swallowed so the link never wedges.
  always_comb begin
    rsp_valid_c    = '0;
    umi_in_ready_c = 1'b0;
    if (!fifo_empty) begin
      rsp_valid_c[head] = bus.umi_in_valid;
      umi_in_ready_c    = bus.rsp_ready[head];
    end else begin
      umi_in_ready_c = bus.umi_in_valid;
    end
  end

  assign pop  = !fifo_empty && bus.umi_in_valid && umi_in_ready_c;
  assign drop = fifo_empty && bus.umi_in_valid;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= IDLE;
      last_grant <= IW'(N-1);
      out_packet <= '0;
      out_valid  <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        out_packet <= bus.req_packet[32'(grant)*256 +: 256];
        out_valid  <= 1'b1;
        last_grant <= grant;
      end else if (state == SEND && bus.umi_out_ready) begin
        out_valid <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (drop) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) id_fifo[wr_ptr] <= grant;
  end

  assign bus.req_ready      = req_ready_c;
  assign bus.umi_out_packet = out_packet;
  assign bus.umi_out_valid  = out_valid;
  assign bus.umi_in_ready   = umi_in_ready_c;
  assign bus.rsp_packet     = bus.umi_in_packet;
  assign bus.rsp_valid      = rsp_valid_c;
  assign err_unexpected     = err;
  assign outstanding        = count;

endmodule

// File: doc/umi_out_arbiter.md
# umi_out_arbiter

Round-robin arbiter sharing one UMI outbound port among N requesters (e.g. several AXI-to-UMI bridges), and router steering UMI read responses on the shared inbound port back to the requester that issued the read. Sits between the bridges and the single UMI link to the device. Reads are tracked in issue order by a requester-ID FIFO. Writes are posted and generate no tracked response.

## Interface
- N, 2: number of requesters, 2..8.
- DEPTH, 4: maximum outstanding reads; power of 2, ≥2.
- clk  in  1  sole clock, rising edge.
- nreset  in  1  asynchronous active-low reset.
- req_packet  in  N*256  requester packets; requester i at [i*256 +: 256].
- req_valid  in  N  per-requester packet valid.
- req_ready  out  N  per-requester accept.
- umi_out_packet  out  256  packet to shared outbound port (registered).
- umi_out_valid  out  1  outbound valid (registered).
- umi_out_ready  in  1  outbound ready.
- umi_in_packet  in  256  shared inbound packet (read responses).
- umi_in_valid  in  1  inbound valid.
- umi_in_ready  out  1  inbound accept.
- rsp_packet  out  256  response packet, broadcast to all requesters (= umi_in_packet).
- rsp_valid  out  N  per-requester response valid.
- rsp_ready  in  N  per-requester response ready.
- err_unexpected  out  1  sticky: response arrived with no read outstanding.
- outstanding  out  $clog2(DEPTH)+1  current count of outstanding reads.

## Operation
- Request classification: opcode from umi_unpack/umi_decode of each req_packet; opcode == `UMI_READ` is a read, anything else is posted.
- Eligible[i] = req_valid[i] && !(read[i] && fifo_full).
- Two-state FSM, IDLE / SEND.
- IDLE: grant = first eligible index after last_grant, wrapping modulo N; req_ready[grant] = 1 combinationally, all others 0. No eligible requester → all req_ready = 0, stay IDLE.
- IDLE handshake (req_valid & req_ready on grant): umi_out_packet <= req_packet[grant], umi_out_valid <= 1, last_grant <= grant, go SEND; if read, push grant into ID FIFO.
- SEND: all req_ready = 0; hold umi_out_packet/valid stable until umi_out_ready; on handshake umi_out_valid <= 0, go IDLE.
- Response routing, combinational, FIFO non-empty, head = h: rsp_valid[h] = umi_in_valid, all other rsp_valid = 0, umi_in_ready = rsp_ready[h]; on umi_in_valid && umi_in_ready pop FIFO.
- FIFO empty while umi_in_valid: umi_in_ready = 1 (packet dropped), all rsp_valid = 0, err_unexpected <= 1 (sticky until reset).
- Push and pop in the same cycle: count unchanged, both pointers advance; legal when full (pop frees the slot only on the next cycle for eligibility, since fifo_full is registered state).
- FIFO pointers wrap modulo DEPTH; outstanding = write count minus read count, range 0..DEPTH.

## Timing
- Reset (nreset low, asynchronous): umi_out_valid = 0, umi_out_packet = 0, state = IDLE, last_grant = N-1 (requester 0 wins first), FIFO empty, outstanding = 0, err_unexpected = 0. Combinational outputs follow: req_ready per IDLE rule, rsp_valid = 0, umi_in_ready = 0 unless umi_in_valid.
- Reset mid-transfer: in-flight outbound packet and all outstanding read IDs are discarded; no response from before reset is routed afterward.
- Latency: request accepted in cycle t → umi_out_valid high in t+1. Best-case throughput is one packet per 2 cycles (IDLE bubble between grants).
- Response path: zero-cycle combinational pass-through; no registers between umi_in_* and rsp_*.
- Fairness: a continuously eligible requester waits at most N-1 grants.
- Read blocked by full FIFO does not stall other requesters' writes.

## Test plan
- Single write from requester 1, umi_out_ready = 1 → req_ready[1] high at t, umi_out_valid high at t+1 with identical packet, back to IDLE at t+2; outstanding stays 0.
- N=3, all three valid continuously with writes → grant order 0,1,2,0,1,2; each umi_out packet matches the granted requester.
- Read from requester 2, then read from requester 0; responses A then B on umi_in → A on rsp_valid[2], B on rsp_valid[0]; outstanding 0→1→2→1→0.
- DEPTH=4: four reads issued, fifth read from requester 0 plus write from requester 1 → write granted, read held (req_ready[0] = 0) until a response pops; umi_out_ready held low 5 cycles → packet and valid stable throughout.
- umi_in_valid with FIFO empty → umi_in_ready = 1, no rsp_valid, err_unexpected = 1 and stays 1; assert nreset low mid-SEND with 2 reads outstanding → umi_out_valid = 0, outstanding = 0, err_unexpected = 0 immediately.
